// File: rtl/sram_ctrl_if.sv
// ---------------------------------------------------------------------------
// sram_ctrl_if -- request/response bus of the SRAM controller.
//
// Signals:
//   req_valid  : request present (master -> slave)
//   req_ready  : controller accepts a request this cycle (slave -> master)
//   req_we     : 1 = write, 0 = read
//   req_addr   : request address, DEPTH bits
//   req_data   : write data, WIDTH bits
//   resp_valid : read data valid (slave -> master)
//   resp_ready : consumer takes the response (master -> slave)
//   resp_data  : read data, WIDTH bits
//
// Modports: master = requester side, slave = controller side.
// ---------------------------------------------------------------------------
interface sram_ctrl_if #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [DEPTH-1:0] req_addr;
    logic [WIDTH-1:0] req_data;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_data;

    modport master (
        output req_valid, req_we, req_addr, req_data, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_data, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl -- single-port asynchronous SRAM controller.
//
// Accepts one read or write request at a time over sram_ctrl_if and turns it
// into glitch-free SRAM strobes. Every SRAM_* and RESP_* output comes straight
// from a flop. Writes run SETUP -> PULSE (n_we low) -> HOLD; reads run
// PULSE (n_oe low) -> RESP, where read data is held until consumed.
//
// Ports:
//   clk        : single clock, all state changes on posedge
//   N_RST      : synchronous active-low reset
//   bus        : request/response bus (slave modport)
//   sram_addr  : SRAM address
//   sram_wdata : SRAM write data
//   sram_rdata : SRAM read data (only meaningful while sram_n_oe = 0)
//   sram_n_we  : SRAM write strobe, active-low
//   sram_n_oe  : SRAM output enable, active-low
//
// Parameters: DEPTH (address bits), WIDTH (data bits),
//             WAIT_CYCLES (extra strobe-low cycles).
// Configuration macro: SRAM_CTRL_WAIT_EN -- when defined, each strobe stays
//   low for 1+WAIT_CYCLES cycles using a down-counter; when absent the strobe
//   is low for exactly one cycle and WAIT_CYCLES is unused.
// ---------------------------------------------------------------------------
module sram_ctrl #(
    parameter int DEPTH       = 2,
    parameter int WIDTH       = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             N_RST,
    sram_ctrl_if.slave       bus,
    output logic [DEPTH-1:0] sram_addr,
    output logic [WIDTH-1:0] sram_wdata,
    input  logic [WIDTH-1:0] sram_rdata,
    output logic             sram_n_we,
    output logic             sram_n_oe
);

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        RD_PULSE,
        RESP
    } state_t;

    state_t           state_q, state_d;
    logic [DEPTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic             resp_valid_q, resp_valid_d;
    logic             n_we_q, n_we_d;
    logic             n_oe_q, n_oe_d;
    logic             pulse_done;

`ifdef SRAM_CTRL_WAIT_EN
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES);

    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    // The pulse ends in the cycle where the counter has run down to zero.
    assign pulse_done = (wait_cnt_q == '0);
`else
    assign pulse_done = 1'b1;
`endif

    // Ready is combinational on state so a new request is taken in the very
    // first IDLE cycle after an access.
    assign bus.req_ready  = (state_q == IDLE) && N_RST;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign sram_addr      = addr_q;
    assign sram_wdata     = wdata_q;
    assign sram_n_we      = n_we_q;
    assign sram_n_oe      = n_oe_q;

    // The combinational process computes the next value of every output flop,
    // so strobes are registered and cannot glitch.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned and infers a latch.
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        n_we_d       = 1'b1;
        n_oe_d       = 1'b1;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d = bus.req_addr;
                    if (bus.req_we) begin
                        wdata_d = bus.req_data;
                        state_d = WR_SETUP;
                    end else begin
                        n_oe_d  = 1'b0;
                        state_d = RD_PULSE;
                    end
                end
            end
            WR_SETUP: begin
                n_we_d  = 1'b0;
                state_d = WR_PULSE;
            end
            WR_PULSE: begin
                if (pulse_done) begin
                    state_d = WR_HOLD;
                end else begin
                    n_we_d = 1'b0;
                end
            end
            WR_HOLD: begin
                state_d = IDLE;
            end
            RD_PULSE: begin
                if (pulse_done) begin
                    resp_data_d  = sram_rdata;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    n_oe_d = 1'b0;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef SRAM_CTRL_WAIT_EN
        // Count down while a strobe is low; load on entry to a pulse state.
        wait_cnt_d = '0;
        if (state_q == WR_PULSE || state_q == RD_PULSE) begin
            wait_cnt_d = pulse_done ? '0 : wait_cnt_q - CW'(1);
        end else if (state_d == WR_PULSE || state_d == RD_PULSE) begin
            wait_cnt_d = WAIT_LOAD;
        end
`endif
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values and updates together.
        if (!N_RST) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            n_we_q       <= 1'b1;
            n_oe_q       <= 1'b1;
`ifdef SRAM_CTRL_WAIT_EN
            wait_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            n_we_q       <= n_we_d;
            n_oe_q       <= n_oe_d;
`ifdef SRAM_CTRL_WAIT_EN
            wait_cnt_q   <= wait_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_ctrl -- self-checking bench for sram_ctrl.
//
// A behavioural SRAM sits on the pin side. A transaction-level model tracks
// what the controller must be doing (cycles since the accepted request) and a
// compare process checks every output each cycle on the falling clock edge.
// Directed tests add literal expectations for data, pulse widths, latency and
// reset behaviour. Build with SRAM_CTRL_WAIT_EN to run with WAIT_CYCLES=3.
// ---------------------------------------------------------------------------
module tb_sram_ctrl;

    localparam int DEPTH = 2;
    localparam int WIDTH = 8;
`ifdef SRAM_CTRL_WAIT_EN
    localparam int WC = 3;
    localparam int L  = 4;
`else
    localparam int WC = 1;
    localparam int L  = 1;
`endif

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic [DEPTH-1:0] sram_addr;
    logic [WIDTH-1:0] sram_wdata;
    logic [WIDTH-1:0] sram_rdata;
    logic             sram_n_we;
    logic             sram_n_oe;

    sram_ctrl_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    sram_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .WAIT_CYCLES(WC)) dut (
        .clk        (clk),
        .N_RST      (n_rst),
        .bus        (bus),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_n_we  (sram_n_we),
        .sram_n_oe  (sram_n_oe)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: write on the falling edge of n_we, junk when not enabled.
    logic [WIDTH-1:0] sram_mem [1 << DEPTH];
    always @(negedge sram_n_we) sram_mem[sram_addr] <= sram_wdata;
    assign sram_rdata = sram_n_oe ? 8'hEE : sram_mem[sram_addr];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit               chk_en = 1'b0;
    bit               mdl_busy = 1'b0;
    bit               mdl_we = 1'b0;
    int               mdl_k = 0;
    logic [DEPTH-1:0] mdl_addr = '0;
    logic [WIDTH-1:0] mdl_wdata = '0;
    logic [WIDTH-1:0] mdl_rdata = '0;
    logic [WIDTH-1:0] mdl_mem [1 << DEPTH];

    // mdl_k = index of the current cycle after the accepting edge (1 = first).
    always @(posedge clk) begin
        if (!n_rst) begin
            chk_en    = 1'b1;
            mdl_busy  = 1'b0;
            mdl_addr  = '0;
            mdl_wdata = '0;
        end else if (!mdl_busy) begin
            if (bus.req_valid) begin
                mdl_busy = 1'b1;
                mdl_k    = 1;
                mdl_we   = bus.req_we;
                mdl_addr = bus.req_addr;
                if (bus.req_we) mdl_wdata = bus.req_data;
                else            mdl_rdata = mdl_mem[bus.req_addr];
            end
        end else if (mdl_we) begin
            if (mdl_k == 1) mdl_mem[mdl_addr] = mdl_wdata;  // strobe falls here
            if (mdl_k == L + 2) mdl_busy = 1'b0;
            else                mdl_k++;
        end else begin
            if (mdl_k >= L + 1 && bus.resp_ready) mdl_busy = 1'b0;
            else                                  mdl_k++;
        end
    end

    logic e_we, e_oe, e_rv;
    logic prev_we_lo = 1'b0, prev_oe_lo = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            e_we = !(mdl_busy && mdl_we && mdl_k >= 2 && mdl_k <= L + 1);
            e_oe = !(mdl_busy && !mdl_we && mdl_k <= L);
            e_rv = mdl_busy && !mdl_we && mdl_k >= L + 1;
            check("n_we", 32'(sram_n_we), 32'(e_we));
            check("n_oe", 32'(sram_n_oe), 32'(e_oe));
            check("resp_valid", 32'(bus.resp_valid), 32'(e_rv));
            check("req_ready", 32'(bus.req_ready), 32'(!mdl_busy && n_rst));
            check("sram_addr", 32'(sram_addr), 32'(mdl_addr));
            check("sram_wdata", 32'(sram_wdata), 32'(mdl_wdata));
            if (e_rv) check("resp_data", 32'(bus.resp_data), 32'(mdl_rdata));
            check("strobe_overlap", 32'(sram_n_we | sram_n_oe), 32'(1));
            check("strobe_gap", 32'((prev_we_lo && !sram_n_oe) || (prev_oe_lo && !sram_n_we)), 32'(0));
            prev_we_lo = !sram_n_we;
            prev_oe_lo = !sram_n_oe;
        end
    end

    // Strobe-width monitor.
    int we_run = 0, we_len = 0, we_pulses = 0;
    int oe_run = 0, oe_len = 0;
    always @(negedge clk) begin
        if (!sram_n_we) we_run++;
        else if (we_run > 0) begin we_len = we_run; we_pulses++; we_run = 0; end
        if (!sram_n_oe) oe_run++;
        else if (oe_run > 0) begin oe_len = oe_run; oe_run = 0; end
    end

    // ---------------- drivers (all start #1 after a posedge) ----------------
    task automatic send_req(input logic we, input logic [DEPTH-1:0] a, input logic [WIDTH-1:0] d);
        logic rdy;
        int   n;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_data  = d;
        rdy = 1'b0;
        n   = 0;
        while (!rdy && n < 50) begin
            @(negedge clk);
            rdy = bus.req_ready;
            @(posedge clk);
            n++;
        end
        #1;
        bus.req_valid = 1'b0;
        if (!rdy) check("handshake_timeout", 32'(rdy), 32'(1));
    endtask

    task automatic wait_idle();
        logic rdy;
        int   n;
        rdy = 1'b0;
        n   = 0;
        while (!rdy && n < 50) begin
            @(negedge clk);
            rdy = bus.req_ready;
            n++;
        end
        if (!rdy) check("idle_timeout", 32'(rdy), 32'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [DEPTH-1:0] a, input int hold,
                           output logic [WIDTH-1:0] data, output int lat);
        logic seen;
        send_req(1'b0, a, '0);
        bus.resp_ready = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 50) begin
            @(negedge clk);
            lat++;
            seen = bus.resp_valid;
        end
        if (!seen) check("resp_timeout", 32'(seen), 32'(1));
        data = bus.resp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.resp_valid), 32'(1));
            check("hold_data", 32'(bus.resp_data), 32'(data));
            check("hold_ready", 32'(bus.req_ready), 32'(0));
            check("hold_n_oe", 32'(sram_n_oe), 32'(1));
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
    endtask

    // ---------------- directed tests ----------------
    logic [WIDTH-1:0] rd;
    int               lat;
    int               p0;
    logic [WIDTH-1:0] exp_vals [4];

    initial begin
        exp_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        bus.req_data   = '0;
        bus.resp_ready = 1'b0;
        n_rst          = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_n_we", 32'(sram_n_we), 32'(1));
        check("rst_n_oe", 32'(sram_n_oe), 32'(1));
        check("rst_addr", 32'(sram_addr), 32'(0));
        check("rst_wdata", 32'(sram_wdata), 32'(0));
        check("rst_resp_valid", 32'(bus.resp_valid), 32'(0));
        check("rst_resp_data", 32'(bus.resp_data), 32'(0));
        check("rst_ready", 32'(bus.req_ready), 32'(0));
        @(posedge clk);
        #1 n_rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.req_ready), 32'(1));
        @(posedge clk);
        #1;

        // Write 0xA5 to 2, read it back.
        send_req(1'b1, 2'd2, 8'hA5);
        wait_idle();
        check("wr_pulse_len", 32'(we_len), 32'(L));
        do_read(2'd2, 0, rd, lat);
        check("rd_a5", 32'(rd), 32'(8'hA5));
        check("rd_latency", 32'(lat), 32'(L + 1));
        check("rd_pulse_len", 32'(oe_len), 32'(L));

        // Response stalled for 5 cycles.
        do_read(2'd2, 5, rd, lat);
        check("rd_hold_a5", 32'(rd), 32'(8'hA5));

        // Back-to-back writes, then reads in reverse order.
        for (int i = 0; i < 4; i++) send_req(1'b1, DEPTH'(i), exp_vals[i]);
        for (int i = 3; i >= 0; i--) begin
            do_read(DEPTH'(i), 0, rd, lat);
            check("b2b_read", 32'(rd), 32'(exp_vals[i]));
        end

        // REQ_VALID toggling with junk while a write is in progress.
        p0 = we_pulses;
        send_req(1'b1, 2'd1, 8'h5A);
        for (int i = 1; i <= L + 2; i++) begin
            bus.req_valid = i[0];
            bus.req_we    = 1'($urandom);
            bus.req_addr  = DEPTH'($urandom);
            bus.req_data  = WIDTH'($urandom);
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        wait_idle();
        check("toggle_we_pulses", 32'(we_pulses - p0), 32'(1));
        do_read(2'd1, 0, rd, lat);
        check("toggle_read", 32'(rd), 32'(8'h5A));

        // Reset during the write pulse: strobe released, write retained.
        send_req(1'b1, 2'd0, 8'h77);
        @(posedge clk);
        #1 n_rst = 1'b0;
        @(negedge clk);
        check("pre_rst_we_low", 32'(sram_n_we), 32'(0));
        @(posedge clk);
        @(negedge clk);
        check("rst_we_released", 32'(sram_n_we), 32'(1));
        check("rst_mid_ready0", 32'(bus.req_ready), 32'(0));
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_ready1", 32'(bus.req_ready), 32'(0));
        @(posedge clk);
        #1 n_rst = 1'b1;
        @(negedge clk);
        check("rst_release_ready", 32'(bus.req_ready), 32'(1));
        @(posedge clk);
        #1;
        do_read(2'd0, 0, rd, lat);
        check("rst_write_kept", 32'(rd), 32'(8'h77));

        // Reset while a response is pending drops it.
        send_req(1'b0, 2'd3, '0);
        bus.resp_ready = 1'b0;
        repeat (L + 1) @(posedge clk);
        #1 n_rst = 1'b0;
        @(negedge clk);
        check("pend_resp_valid", 32'(bus.resp_valid), 32'(1));
        @(posedge clk);
        @(negedge clk);
        check("drop_resp_valid", 32'(bus.resp_valid), 32'(0));
        @(posedge clk);
        #1 n_rst = 1'b1;
        @(posedge clk);
        #1;
        do_read(2'd3, 0, rd, lat);
        check("after_drop_read", 32'(rd), 32'(8'h44));

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
